// File: rtl/sensor_cmd_buffer.sv
// rtl/sensor_cmd_buffer.sv - AHB-side command FIFO and sensor sample register file
//
// Sits behind the AHB slave. Address bit 15 selects the region:
//   1 = command region: writes push 16-bit commands into a FIFO drained by the
//       sensor controller; reads return {count, full, empty} status.
//   0 = sensor region: reads return one of NUM_SENSORS 32-bit sample registers.
//
// Ports:
//   HCLK, HRESET                      clock, synchronous active-high reset
//   renable, wenable                  one-cycle transfer strobes from the slave
//   address, command_data, data_size  transfer address / write data / HSIZE copy
//   sensor_data, slave_wait           registered read data, busy indication
//   cmd_valid, cmd_data, cmd_ready    command FIFO head towards the controller
//   sample_valid/index/value          sample register update from the front end
//   size_err                          sticky illegal-size / r+w collision flag
module sensor_cmd_buffer #(
  parameter int FIFO_DEPTH  = 8,
  parameter int NUM_SENSORS = 8,
  localparam int IW = $clog2(NUM_SENSORS),
  localparam int PW = $clog2(FIFO_DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          HCLK,
  input  logic          HRESET,
  input  logic          renable,
  input  logic          wenable,
  input  logic [15:0]   address,
  input  logic [15:0]   command_data,
  input  logic [2:0]    data_size,
  output logic [31:0]   sensor_data,
  output logic          slave_wait,
  output logic          cmd_valid,
  output logic [15:0]   cmd_data,
  input  logic          cmd_ready,
  input  logic          sample_valid,
  input  logic [IW-1:0] sample_index,
  input  logic [31:0]   sample_value,
  output logic          size_err
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_RD       = 2'd1;
  localparam logic [1:0] ST_WR_STALL = 2'd2;

  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [1:0]    state;
  logic          rd_region_q;
  logic [IW-1:0] rd_idx_q;
  logic [15:0]   pending_q;
  logic [15:0]   last_pop_q;

  logic [15:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  logic [31:0]   sample_regs [NUM_SENSORS];

  logic full, empty, pop, push, push_idle, push_stall, stall_go, rd_go;
  logic strobe, bad_xfer;
  logic [15:0] push_data;
  logic [31:0] rd_sample, rd_status;
  logic [7:0]  count8;

  logic unused_addr_bits;
  assign unused_addr_bits = ^address[14:IW];

  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);
  assign pop   = cmd_ready && !empty;

  assign strobe   = (state == ST_IDLE) && (renable || wenable);
  assign bad_xfer = strobe && ((data_size != 3'b010) || (renable && wenable));

  // A simultaneous read/write services the write and drops the read.
  assign rd_go      = (state == ST_IDLE) && renable && !wenable;
  assign push_idle  = (state == ST_IDLE) && wenable && address[15] && !full;
  assign stall_go   = (state == ST_IDLE) && wenable && address[15] && full;
  // A same-edge pop frees the head slot, so a full FIFO can still accept the pending word.
  assign push_stall = (state == ST_WR_STALL) && (pop || !full);
  assign push       = push_idle || push_stall;
  assign push_data  = push_stall ? pending_q : command_data;

  // Write-through so a read completing on the update edge sees the new sample.
  assign rd_sample = (sample_valid && (sample_index == rd_idx_q)) ? sample_value
                                                                  : sample_regs[rd_idx_q];
  assign count8    = 8'(count);
  assign rd_status = {16'h0, count8, 6'b0, full, empty};

  assign slave_wait = (state != ST_IDLE);
  assign cmd_valid  = !empty;
  // Empty slots hold stale data, so show the last popped word instead.
  assign cmd_data   = empty ? last_pop_q : mem[rd_ptr];

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state       <= ST_IDLE;
      rd_region_q <= 1'b0;
      rd_idx_q    <= '0;
      pending_q   <= '0;
      last_pop_q  <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      sensor_data <= '0;
      size_err    <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      for (int i = 0; i < NUM_SENSORS; i++) sample_regs[i] <= '0;
    end else begin
      if (bad_xfer) size_err <= 1'b1;

      if (sample_valid) sample_regs[sample_index] <= sample_value;

      case (state)
        ST_IDLE: begin
          if (rd_go) begin
            rd_region_q <= address[15];
            rd_idx_q    <= address[IW-1:0];
            state       <= ST_RD;
          end else if (stall_go) begin
            pending_q <= command_data;
            state     <= ST_WR_STALL;
          end
        end
        ST_RD: begin
          sensor_data <= rd_region_q ? rd_status : rd_sample;
          state       <= ST_IDLE;
        end
        ST_WR_STALL: begin
          if (push_stall) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        last_pop_q <= mem[rd_ptr];
        rd_ptr     <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_sensor_cmd_buffer.sv
// tb/tb_sensor_cmd_buffer.sv - self-checking bench for sensor_cmd_buffer
module tb_sensor_cmd_buffer;

  logic        tb_clk;
  logic        HRESET;
  logic        renable, wenable;
  logic [15:0] address, command_data;
  logic [2:0]  data_size;
  logic [31:0] sensor_data;
  logic        slave_wait, cmd_valid, cmd_ready, sample_valid, size_err;
  logic [15:0] cmd_data;
  logic [2:0]  sample_index;
  logic [31:0] sample_value;

  int n_vec;
  int n_bad;

  sensor_cmd_buffer #(.FIFO_DEPTH(8), .NUM_SENSORS(8)) dut (
    .HCLK(tb_clk), .HRESET(HRESET),
    .renable(renable), .wenable(wenable), .address(address),
    .command_data(command_data), .data_size(data_size),
    .sensor_data(sensor_data), .slave_wait(slave_wait),
    .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
    .sample_valid(sample_valid), .sample_index(sample_index),
    .sample_value(sample_value), .size_err(size_err)
  );

  initial tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  typedef struct {
    logic        ren, wen;
    logic [15:0] addr, wdata;
    logic [2:0]  size;
    logic        rdy, sv;
    logic [2:0]  sidx;
    logic [31:0] sval;
    logic [31:0] e_sd;
    logic        e_sw, e_cv;
    logic [15:0] e_cd;
    logic        e_se;
  } vec_t;

  localparam int NV = 25;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic ren, input logic wen, input logic [15:0] addr,
                              input logic [15:0] wdata, input logic [2:0] size,
                              input logic rdy, input logic sv, input logic [2:0] sidx,
                              input logic [31:0] sval, input logic [31:0] e_sd,
                              input logic e_sw, input logic e_cv, input logic [15:0] e_cd,
                              input logic e_se);
    vec_t v;
    v.ren = ren; v.wen = wen; v.addr = addr; v.wdata = wdata; v.size = size;
    v.rdy = rdy; v.sv = sv; v.sidx = sidx; v.sval = sval;
    v.e_sd = e_sd; v.e_sw = e_sw; v.e_cv = e_cv; v.e_cd = e_cd; v.e_se = e_se;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    renable = 0; wenable = 0; address = '0; command_data = '0; data_size = 3'b010;
    cmd_ready = 0; sample_valid = 0; sample_index = '0; sample_value = '0;
  endtask

  task automatic cycle();
    @(posedge tb_clk);
    #1;
  endtask

  task automatic cmd_write(input logic [15:0] d);
    idle_inputs();
    wenable = 1; address = 16'h8000; command_data = d;
    cycle();
    idle_inputs();
  endtask

  task automatic status_read(input string name, input logic [31:0] exp);
    idle_inputs();
    renable = 1; address = 16'h8000;
    cycle();
    idle_inputs();
    cycle();
    chk(name, sensor_data, exp);
  endtask

  localparam logic [2:0] S = 3'b010;

  initial begin
    n_vec = 0;
    n_bad = 0;
    idle_inputs();
    HRESET = 1;
    cycle();
    cycle();
    HRESET = 0;

    //           ren wen addr      wdata     size  rdy sv idx sval           sd             sw cv cd        se
    vecs[0]  = mk(0, 0, 16'h0000, 16'h0000, S,    0, 0, 0, 32'h0,        32'h0,         0, 0, 16'h0000, 0);
    vecs[1]  = mk(0, 0, 16'h0000, 16'h0000, S,    0, 1, 3, 32'hDEAF0CAB, 32'h0,         0, 0, 16'h0000, 0);
    vecs[2]  = mk(1, 0, 16'h0003, 16'h0000, S,    0, 0, 0, 32'h0,        32'h0,         1, 0, 16'h0000, 0);
    vecs[3]  = mk(0, 0, 16'h0000, 16'h0000, S,    0, 0, 0, 32'h0,        32'hDEAF0CAB,  0, 0, 16'h0000, 0);
    vecs[4]  = mk(0, 1, 16'h801F, 16'hF397, S,    0, 0, 0, 32'h0,        32'hDEAF0CAB,  0, 1, 16'hF397, 0);
    vecs[5]  = mk(0, 1, 16'h801F, 16'hDEC2, S,    0, 0, 0, 32'h0,        32'hDEAF0CAB,  0, 1, 16'hF397, 0);
    vecs[6]  = mk(1, 0, 16'h8000, 16'h0000, S,    0, 0, 0, 32'h0,        32'hDEAF0CAB,  1, 1, 16'hF397, 0);
    vecs[7]  = mk(0, 0, 16'h0000, 16'h0000, S,    0, 0, 0, 32'h0,        32'h00000200,  0, 1, 16'hF397, 0);
    vecs[8]  = mk(0, 0, 16'h0000, 16'h0000, S,    1, 0, 0, 32'h0,        32'h00000200,  0, 1, 16'hDEC2, 0);
    vecs[9]  = mk(0, 0, 16'h0000, 16'h0000, S,    1, 0, 0, 32'h0,        32'h00000200,  0, 0, 16'hDEC2, 0);
    vecs[10] = mk(0, 0, 16'h0000, 16'h0000, S,    1, 0, 0, 32'h0,        32'h00000200,  0, 0, 16'hDEC2, 0);
    vecs[11] = mk(1, 0, 16'h8000, 16'h0000, S,    0, 0, 0, 32'h0,        32'h00000200,  1, 0, 16'hDEC2, 0);
    vecs[12] = mk(0, 0, 16'h0000, 16'h0000, S,    0, 0, 0, 32'h0,        32'h00000001,  0, 0, 16'hDEC2, 0);
    vecs[13] = mk(0, 1, 16'h0005, 16'h1234, S,    0, 0, 0, 32'h0,        32'h00000001,  0, 0, 16'hDEC2, 0);
    vecs[14] = mk(1, 0, 16'h7FFB, 16'h0000, S,    0, 0, 0, 32'h0,        32'h00000001,  1, 0, 16'hDEC2, 0);
    vecs[15] = mk(0, 0, 16'h0000, 16'h0000, S,    0, 0, 0, 32'h0,        32'hDEAF0CAB,  0, 0, 16'hDEC2, 0);
    vecs[16] = mk(1, 0, 16'h0005, 16'h0000, S,    0, 0, 0, 32'h0,        32'hDEAF0CAB,  1, 0, 16'hDEC2, 0);
    vecs[17] = mk(0, 0, 16'h0000, 16'h0000, S,    0, 1, 5, 32'hFEEDABAD, 32'hFEEDABAD,  0, 0, 16'hDEC2, 0);
    vecs[18] = mk(1, 0, 16'h0003, 16'h0000, S,    0, 0, 0, 32'h0,        32'hFEEDABAD,  1, 0, 16'hDEC2, 0);
    vecs[19] = mk(0, 1, 16'h8001, 16'hAAAA, S,    0, 0, 0, 32'h0,        32'hDEAF0CAB,  0, 0, 16'hDEC2, 0);
    vecs[20] = mk(1, 1, 16'h8000, 16'h5A5A, 3'b000, 0, 0, 0, 32'h0,      32'hDEAF0CAB,  0, 1, 16'h5A5A, 1);
    vecs[21] = mk(0, 0, 16'h0000, 16'h0000, S,    0, 0, 0, 32'h0,        32'hDEAF0CAB,  0, 1, 16'h5A5A, 1);
    vecs[22] = mk(1, 0, 16'h8000, 16'h0000, S,    0, 0, 0, 32'h0,        32'hDEAF0CAB,  1, 1, 16'h5A5A, 1);
    vecs[23] = mk(0, 0, 16'h0000, 16'h0000, S,    0, 0, 0, 32'h0,        32'h00000100,  0, 1, 16'h5A5A, 1);
    vecs[24] = mk(0, 0, 16'h0000, 16'h0000, S,    1, 0, 0, 32'h0,        32'h00000100,  0, 0, 16'h5A5A, 1);

    for (int i = 0; i < NV; i++) begin
      renable = vecs[i].ren; wenable = vecs[i].wen; address = vecs[i].addr;
      command_data = vecs[i].wdata; data_size = vecs[i].size; cmd_ready = vecs[i].rdy;
      sample_valid = vecs[i].sv; sample_index = vecs[i].sidx; sample_value = vecs[i].sval;
      cycle();
      chk($sformatf("v%0d sensor_data", i), sensor_data, vecs[i].e_sd);
      chk($sformatf("v%0d slave_wait", i), {31'b0, slave_wait}, {31'b0, vecs[i].e_sw});
      chk($sformatf("v%0d cmd_valid", i), {31'b0, cmd_valid}, {31'b0, vecs[i].e_cv});
      chk($sformatf("v%0d cmd_data", i), {16'b0, cmd_data}, {16'b0, vecs[i].e_cd});
      chk($sformatf("v%0d size_err", i), {31'b0, size_err}, {31'b0, vecs[i].e_se});
    end
    idle_inputs();

    // Full FIFO: the ninth write stalls until a pop frees a slot.
    for (int i = 0; i < 8; i++) cmd_write(16'h1000 + 16'(i));
    chk("fill cmd_data", {16'b0, cmd_data}, 32'h1000);
    status_read("fill status", 32'h00000802);
    cmd_write(16'h9618);
    chk("stall wait", {31'b0, slave_wait}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk($sformatf("stall hold %0d", i), {31'b0, slave_wait}, 32'd1);
    end
    chk("stall head", {16'b0, cmd_data}, 32'h1000);
    cmd_ready = 1;
    cycle();
    cmd_ready = 0;
    chk("stall release", {31'b0, slave_wait}, 32'd0);
    chk("release head", {16'b0, cmd_data}, 32'h1001);
    status_read("release status", 32'h00000802);
    for (int i = 0; i < 8; i++) begin
      logic [15:0] e;
      e = (i == 7) ? 16'h9618 : 16'h1001 + 16'(i);
      chk($sformatf("drain %0d", i), {16'b0, cmd_data}, {16'b0, e});
      cmd_ready = 1;
      cycle();
      cmd_ready = 0;
    end
    chk("drained valid", {31'b0, cmd_valid}, 32'd0);
    chk("drained hold", {16'b0, cmd_data}, 32'h9618);

    // Reset while stalled on a full FIFO.
    for (int i = 0; i < 8; i++) cmd_write(16'h2000 + 16'(i));
    cmd_write(16'h3333);
    chk("restall wait", {31'b0, slave_wait}, 32'd1);
    HRESET = 1;
    cycle();
    HRESET = 0;
    chk("rst slave_wait", {31'b0, slave_wait}, 32'd0);
    chk("rst cmd_valid", {31'b0, cmd_valid}, 32'd0);
    chk("rst cmd_data", {16'b0, cmd_data}, 32'h0);
    chk("rst sensor_data", sensor_data, 32'h0);
    chk("rst size_err", {31'b0, size_err}, 32'd0);
    status_read("rst status", 32'h00000001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
